// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and Karatsuba phase encoding for the twiddle multiplier
package fft_pkg;

    localparam int TWIDDLE_WIDTH_DEFAULT = 10;
    localparam int TWIDDLE_ONE           = 1 << (TWIDDLE_WIDTH_DEFAULT - 1);

    typedef enum logic [1:0] {
        KAR_IDLE = 2'd0,
        KAR_PF   = 2'd1,
        KAR_PR   = 2'd2,
        KAR_PI   = 2'd3
    } kar_phase_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_add.sv
// rtl/mult_add.sv - signed multiply-add p = a*b + c, wrapping to P bits
module mult_add #(
    parameter int A = 25,
    parameter int B = 11,
    parameter int C = 35,
    parameter int P = 35
) (
    input  logic signed [A-1:0] a_i,
    input  logic signed [B-1:0] b_i,
    input  logic signed [C-1:0] c_i,
    output logic signed [P-1:0] p_o
);

    logic signed [P-1:0] a_ext;
    logic signed [P-1:0] b_ext;
    logic signed [P-1:0] c_ext;

    assign a_ext = P'(a_i);
    assign b_ext = P'(b_i);
    assign c_ext = P'(c_i);
    assign p_o   = a_ext * b_ext + c_ext;

endmodule

// File: rtl/fft_r22sdf_mul_sched.sv
// rtl/fft_r22sdf_mul_sched.sv - round-robin shared complex twiddle multiplier, 3-phase Karatsuba
module fft_r22sdf_mul_sched
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int NREQ          = 2,
    parameter int IDW           = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid_i,
    output logic [NREQ-1:0]                 req_ready_o,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_x_re_i,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_x_im_i,
    input  logic [NREQ*TWIDDLE_WIDTH-1:0]   req_w_re_i,
    input  logic [NREQ*TWIDDLE_WIDTH-1:0]   req_w_im_i,
    input  logic [NREQ*NLOG2-1:0]           req_ctr_i,
    output logic                            rsp_valid_o,
    output logic [IDW-1:0]                  rsp_id_o,
    output logic [NLOG2-1:0]                rsp_ctr_o,
    output logic signed [DATA_WIDTH-1:0]    z_re_o,
    output logic signed [DATA_WIDTH-1:0]    z_im_o
);

    localparam int BW = TWIDDLE_WIDTH + 1;
    localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;

    kar_phase_e                       state_q;
    logic [IDW-1:0]                   rr_q, id_q;
    logic signed [DATA_WIDTH-1:0]     x_re_q, x_im_q;
    logic signed [TWIDDLE_WIDTH-1:0]  w_re_q, w_im_q;
    logic [NLOG2-1:0]                 ctr_q;
    logic signed [PW-1:0]             kar_f_q;
    logic signed [DATA_WIDTH-1:0]     kar_r_q;
    logic                             rsp_valid_q;
    logic [IDW-1:0]                   rsp_id_q;
    logic [NLOG2-1:0]                 rsp_ctr_q;
    logic signed [DATA_WIDTH-1:0]     z_re_q, z_im_q;

    logic                             grant_found, accept;
    logic [IDW-1:0]                   grant_id, rr_d;
    logic signed [DATA_WIDTH-1:0]     sel_x_re, sel_x_im;
    logic signed [TWIDDLE_WIDTH-1:0]  sel_w_re, sel_w_im;
    logic [NLOG2-1:0]                 sel_ctr;
    logic signed [DATA_WIDTH-1:0]     mul_a;
    logic signed [BW-1:0]             mul_b;
    logic signed [PW-1:0]             mul_c, mul_p;
    int                               pos;

    // Scan offsets from the rr pointer; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        rr_d        = rr_q;
        sel_x_re    = '0;
        sel_x_im    = '0;
        sel_w_re    = '0;
        sel_w_im    = '0;
        sel_ctr     = '0;
        pos         = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(rr_q) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && (k == pos) && req_valid_i[k]) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(k);
                    rr_d        = IDW'((k + 1) % NREQ);
                    sel_x_re    = req_x_re_i[k*DATA_WIDTH +: DATA_WIDTH];
                    sel_x_im    = req_x_im_i[k*DATA_WIDTH +: DATA_WIDTH];
                    sel_w_re    = req_w_re_i[k*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
                    sel_w_im    = req_w_im_i[k*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
                    sel_ctr     = req_ctr_i[k*NLOG2 +: NLOG2];
                end
            end
        end
    end

    assign accept = grant_found && ((state_q == KAR_IDLE) || (state_q == KAR_PI));

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready_o[k] = accept && (grant_id == IDW'(k));
        end
    end

    // kar_f = (xr-xi)wr; real = xi(wr-wi) + kar_f; imag = xr(wr+wi) - kar_f
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        mul_c = '0;
        case (state_q)
            KAR_PF: begin
                mul_a = x_re_q - x_im_q;
                mul_b = BW'(w_re_q);
            end
            KAR_PR: begin
                mul_a = x_im_q;
                mul_b = BW'(w_re_q) - BW'(w_im_q);
                mul_c = kar_f_q;
            end
            KAR_PI: begin
                mul_a = x_re_q;
                mul_b = BW'(w_re_q) + BW'(w_im_q);
                mul_c = -kar_f_q;
            end
            default: ;
        endcase
    end

    mult_add #(
        .A(DATA_WIDTH),
        .B(BW),
        .C(PW),
        .P(PW)
    ) twiddle_multiply (
        .a_i(mul_a),
        .b_i(mul_b),
        .c_i(mul_c),
        .p_o(mul_p)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= KAR_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            w_re_q      <= '0;
            w_im_q      <= '0;
            ctr_q       <= '0;
            kar_f_q     <= '0;
            kar_r_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ctr_q   <= '0;
            z_re_q      <= '0;
            z_im_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                KAR_PF: begin
                    kar_f_q <= mul_p;
                    state_q <= KAR_PR;
                end
                KAR_PR: begin
                    kar_r_q <= mul_p[PW-2:TWIDDLE_WIDTH-1];
                    state_q <= KAR_PI;
                end
                KAR_PI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_ctr_q   <= ctr_q;
                    z_re_q      <= kar_r_q;
                    z_im_q      <= mul_p[PW-2:TWIDDLE_WIDTH-1];
                    state_q     <= KAR_IDLE;
                end
                default: state_q <= KAR_IDLE;
            endcase
            if (accept) begin
                state_q <= KAR_PF;
                x_re_q  <= sel_x_re;
                x_im_q  <= sel_x_im;
                w_re_q  <= sel_w_re;
                w_im_q  <= sel_w_im;
                ctr_q   <= sel_ctr;
                id_q    <= grant_id;
                rr_q    <= rr_d;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_ctr_o   = rsp_ctr_q;
    assign z_re_o      = z_re_q;
    assign z_im_o      = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_mul_sched.sv
// tb/tb_fft_r22sdf_mul_sched.sv - randomized and directed bench with behavioural scoreboard
module tb_fft_r22sdf_mul_sched;

    localparam int DW  = 25;
    localparam int TW  = 10;
    localparam int NL  = 10;
    localparam int NR  = 2;
    localparam int IDW = 1;

    logic            clk_i = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   v = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_x_re, req_x_im;
    logic [NR*TW-1:0] req_w_re, req_w_im;
    logic [NR*NL-1:0] req_ctr;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [NL-1:0]   rsp_ctr;
    logic [DW-1:0]   z_re, z_im;

    logic [DW-1:0] oxr [NR];
    logic [DW-1:0] oxi [NR];
    logic [TW-1:0] owr [NR];
    logic [TW-1:0] owi [NR];
    logic [NL-1:0] octr[NR];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc = cyc + 1;

    genvar g;
    for (g = 0; g < NR; g++) begin : g_pack
        assign req_x_re[g*DW +: DW] = oxr[g];
        assign req_x_im[g*DW +: DW] = oxi[g];
        assign req_w_re[g*TW +: TW] = owr[g];
        assign req_w_im[g*TW +: TW] = owi[g];
        assign req_ctr[g*NL +: NL]  = octr[g];
    end

    fft_r22sdf_mul_sched #(
        .DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .NREQ(NR), .IDW(IDW)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(v), .req_ready_o(req_ready),
        .req_x_re_i(req_x_re), .req_x_im_i(req_x_im),
        .req_w_re_i(req_w_re), .req_w_im_i(req_w_im),
        .req_ctr_i(req_ctr),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_ctr_o(rsp_ctr),
        .z_re_o(z_re), .z_im_o(z_im)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] z25(input int val);
        return val[DW-1:0];
    endfunction

    // floor((x*w) / 2^(TW-1)) of the complex product, wrapped to DW bits
    function automatic logic [DW-1:0] mdl_z(input longint xr, input longint xi,
                                            input longint wr, input longint wi, input bit imag);
        longint p;
        p = imag ? (xr * wi + xi * wr) : (xr * wr - xi * wi);
        p = p >>> (TW - 1);
        return p[DW-1:0];
    endfunction

    typedef struct {
        int            due;
        int            id;
        logic [NL-1:0] ctr;
        logic [DW-1:0] zr;
        logic [DW-1:0] zi;
    } rsp_t;

    rsp_t          pend[$];
    rsp_t          r;
    int            rr_m = 0;
    int            last_acc = -1000;
    int            n_acc = 0;
    int            gid, pos;
    logic [NR-1:0] exp_ready, acc_flag = '0, prev_v = '0, prev_acc = '0;
    logic          erv;
    logic [IDW-1:0] e_id = '0;
    logic [NL-1:0] e_ctr = '0;
    logic [DW-1:0] e_zr = '0, e_zi = '0;

    always @(negedge clk_i) begin
        if (!rst_n) begin
            pend.delete();
            rr_m = 0; last_acc = -1000;
            e_id = '0; e_ctr = '0; e_zr = '0; e_zi = '0;
            acc_flag = '0; prev_v = '0; prev_acc = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_z", {z_re, z_im}, 0);
            chk("rst_id_ctr", {rsp_id, rsp_ctr}, 0);
        end else begin
            for (int k = 0; k < NR; k++)
                chk("protocol_drop", prev_v[k] && !prev_acc[k] && !v[k], 0);
            exp_ready = '0;
            gid = -1;
            if (cyc >= last_acc + 3) begin
                for (int i = 0; i < NR; i++) begin
                    pos = (rr_m + i) % NR;
                    if (gid < 0 && v[pos]) gid = pos;
                end
            end
            if (gid >= 0) exp_ready[gid] = 1'b1;
            chk("ready", req_ready, exp_ready);
            erv = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                erv = 1'b1;
                e_id = IDW'(r.id); e_ctr = r.ctr; e_zr = r.zr; e_zi = r.zi;
            end
            chk("rsp_valid", rsp_valid, erv);
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_ctr", rsp_ctr, e_ctr);
            chk("z_re", z_re, e_zr);
            chk("z_im", z_im, e_zi);
            if (gid >= 0) begin
                r.due = cyc + 4;
                r.id  = gid;
                r.ctr = octr[gid];
                r.zr  = mdl_z($signed(oxr[gid]), $signed(oxi[gid]), $signed(owr[gid]), $signed(owi[gid]), 1'b0);
                r.zi  = mdl_z($signed(oxr[gid]), $signed(oxi[gid]), $signed(owr[gid]), $signed(owi[gid]), 1'b1);
                pend.push_back(r);
                rr_m = (gid + 1) % NR;
                last_acc = cyc;
                acc_flag[gid] = 1'b1;
                n_acc++;
            end
            prev_v = v;
            prev_acc = exp_ready;
        end
    end

    task automatic set_op(input int k, input int xr, input int xi, input int wr, input int wi, input int ctr);
        oxr[k] = DW'(xr); oxi[k] = DW'(xi);
        owr[k] = TW'(wr); owi[k] = TW'(wi);
        octr[k] = NL'(ctr);
    endtask

    task automatic rand_op(input int k);
        set_op(k, int'($urandom_range(0, 16777214)) - 8388607, int'($urandom_range(0, 16777214)) - 8388607,
               int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
               int'($urandom_range(0, 1023)));
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    int sq_xr[4], sq_xi[4], sq_wr[4], sq_wi[4], sq_zr[4], sq_zi[4];

    task automatic set_seq(input int j, input int xr, input int xi, input int wr, input int wi,
                           input int zr, input int zi);
        sq_xr[j] = xr; sq_xi[j] = xi; sq_wr[j] = wr; sq_wi[j] = wi; sq_zr[j] = zr; sq_zi[j] = zi;
    endtask

    // req0 kept valid back to back; ops accepted at 3j, responses at 3j+4
    task automatic run_seq(input string nm, input int n);
        bit rv;
        for (int c = 0; c <= 3 * n + 3; c++) begin
            if (c == 0) begin
                set_op(0, sq_xr[0], sq_xi[0], sq_wr[0], sq_wi[0], 7);
                v = 2'b01;
            end else if (c % 3 == 1 && c / 3 < n) begin
                if (c / 3 + 1 < n) set_op(0, sq_xr[c/3+1], sq_xi[c/3+1], sq_wr[c/3+1], sq_wi[c/3+1], 7 + c / 3 + 1);
                else v = 2'b00;
            end
            @(negedge clk_i);
            chk({nm, "_ready"}, req_ready, (c % 3 == 0 && c / 3 < n) ? 2'b01 : 2'b00);
            rv = (c >= 4) && ((c - 4) % 3 == 0) && ((c - 4) / 3 < n);
            chk({nm, "_rsp_valid"}, rsp_valid, rv);
            if (rv) begin
                chk({nm, "_id"}, rsp_id, 0);
                chk({nm, "_ctr"}, rsp_ctr, 7 + (c - 4) / 3);
                chk({nm, "_z_re"}, z_re, z25(sq_zr[(c-4)/3]));
                chk({nm, "_z_im"}, z_im, z25(sq_zi[(c-4)/3]));
            end
            next_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        v = '0;
        rst_n = 1'b0;
        repeat (n) next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target, lim;
        for (int k = 0; k < NR; k++) set_op(k, 0, 0, 0, 0, 0);

        chk("pin_t1_re", mdl_z(100, 50, 256, -256, 1'b0), z25(75));
        chk("pin_t1_im", mdl_z(100, 50, 256, -256, 1'b1), z25(-25));
        chk("pin_t2_re", mdl_z(100, 50, 511, 0, 1'b0), z25(99));
        chk("pin_floor_neg", mdl_z(-1, 0, 256, 0, 1'b0), z25(-1));
        chk("pin_floor_pos", mdl_z(1, 0, 256, 0, 1'b0), z25(0));

        repeat (3) next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();

        set_seq(0, 100, 50, 256, -256, 75, -25);
        run_seq("t1_single", 1);

        set_seq(0, 100, 50, 0, 256, -25, 50);
        set_seq(1, 100, 50, 256, -256, 75, -25);
        set_seq(2, 100, 50, 511, 0, 99, 49);
        run_seq("t2_b2b", 3);

        set_seq(0, -1, 0, 256, 0, -1, 0);
        set_seq(1, 1, 0, 256, 0, 0, 0);
        run_seq("t4_floor", 2);

        do_reset(2);
        rand_op(0); rand_op(1);
        v = 2'b11;
        for (int c = 0; c <= 13; c++) begin
            if (c % 3 == 1) rand_op(((c - 1) / 3) % 2);
            @(negedge clk_i);
            chk("t3_ready", req_ready, (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            chk("t3_rsp_valid", rsp_valid, (c >= 4) && ((c - 4) % 3 == 0));
            if (c >= 4 && (c - 4) % 3 == 0) chk("t3_rsp_id", rsp_id, ((c - 4) / 3) % 2);
            next_cycle();
        end
        do_reset(2);
        repeat (2) next_cycle();

        set_seq(0, 3, 4, 100, 200, -1, 1);
        run_seq("t5_pre", 1);
        set_op(0, 3, 4, 100, 200, 9);
        v = 2'b01;
        next_cycle();
        v = 2'b00;
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_z", {z_re, z_im}, 0);
        chk("t5_async_valid_id_ctr", {rsp_valid, rsp_id, rsp_ctr}, 0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (4) next_cycle();
        run_seq("t5_post", 1);

        acc_flag = '0;
        target = n_acc + 2000;
        lim = cyc + 30000;
        while (n_acc < target && cyc < lim) begin
            for (int k = 0; k < NR; k++) begin
                if (acc_flag[k]) begin v[k] = 1'b0; acc_flag[k] = 1'b0; end
                if (!v[k] && $urandom_range(0, 99) < 40) begin rand_op(k); v[k] = 1'b1; end
            end
            next_cycle();
        end
        chk("t6_ops_done", n_acc >= target, 1);
        lim = cyc + 100;
        while (v != '0 && cyc < lim) begin
            for (int k = 0; k < NR; k++)
                if (acc_flag[k]) begin v[k] = 1'b0; acc_flag[k] = 1'b0; end
            next_cycle();
        end
        chk("t6_drain", v, 0);
        repeat (8) next_cycle();
        chk("t6_pending_empty", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
